// File: rtl/fetch_buffer.sv
// Dual-issue fetch buffer: circular FIFO between the icache/predictor side and decode.
// Accepts up to two compacted entries per cycle and presents up to two to the decoder one cycle later.
module fetch_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [1:0]  fetch_valid,
    input  logic [63:0] fetch_pc,
    input  logic [63:0] fetch_inst,
    input  logic [1:0]  fetch_pretaken,
    input  logic [63:0] fetch_pre_addr,
    input  logic [1:0]  fetch_is_exception,
    input  logic [13:0] fetch_exception_cause,
    output logic        fetch_ready,
    input  logic        get_data_req,
    output logic [1:0]  valid,
    output logic [63:0] pc,
    output logic [63:0] inst,
    output logic [1:0]  pretaken,
    output logic [63:0] pre_addr_in,
    output logic [1:0]  is_exception,
    output logic [13:0] exception_cause
);
    localparam int AW    = $clog2(DEPTH);
    localparam int SLOTS = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pretaken;
        logic [31:0] pre_addr;
        logic        is_exc;
        logic [6:0]  cause;
    } entry_t;

    entry_t mem [DEPTH];

    logic [AW:0]   count;
    logic [AW-1:0] head, tail;
    logic          wr_en;
    logic [1:0]    wr_num, rd_num;

    entry_t [SLOTS-1:0] in_e;
    entry_t [SLOTS-1:0] rd_e;
    entry_t [SLOTS-1:0] out_e;

    genvar g;
    generate
        for (g = 0; g < SLOTS; g++) begin : g_slot
            assign in_e[g] = '{pc:       fetch_pc[g*32 +: 32],
                               inst:     fetch_inst[g*32 +: 32],
                               pretaken: fetch_pretaken[g],
                               pre_addr: fetch_pre_addr[g*32 +: 32],
                               is_exc:   fetch_is_exception[g],
                               cause:    fetch_exception_cause[g*7 +: 7]};
            assign rd_e[g] = mem[head + AW'(g)];

            assign pc[g*32 +: 32]             = out_e[g].pc;
            assign inst[g*32 +: 32]           = out_e[g].inst;
            assign pretaken[g]                = out_e[g].pretaken;
            assign pre_addr_in[g*32 +: 32]    = out_e[g].pre_addr;
            assign is_exception[g]            = out_e[g].is_exc;
            assign exception_cause[g*7 +: 7]  = out_e[g].cause;
        end
    endgenerate

    // Room for a full pair is required even when only one slot is valid.
    assign fetch_ready = (count <= (AW+1)'(DEPTH - 2)) && !flush;
    assign wr_en       = (fetch_valid != 2'b00) && fetch_ready;
    assign wr_num      = wr_en ? (2'(fetch_valid[0]) + 2'(fetch_valid[1])) : 2'd0;
    // Only entries already stored before this edge are eligible to be popped.
    assign rd_num      = !get_data_req       ? 2'd0 :
                         (count >= (AW+1)'(2)) ? 2'd2 : {1'b0, count[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(rd_num);
            tail  <= tail + AW'(wr_num);
            count <= count + (AW+1)'(wr_num) - (AW+1)'(rd_num);
        end
    end

    // Storage is left unreset; pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[tail] <= fetch_valid[0] ? in_e[0] : in_e[1];
            if (&fetch_valid)
                mem[tail + AW'(1)] <= in_e[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            out_e <= '0;
        end else if (flush || !get_data_req) begin
            valid <= '0;
        end else begin
            valid <= (rd_num == 2'd2) ? 2'b11 : (rd_num == 2'd1) ? 2'b01 : 2'b00;
            if (rd_num != 2'd0) out_e[0] <= rd_e[0];
            if (rd_num == 2'd2) out_e[1] <= rd_e[1];
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: vector table with a queue-based reference model feeding a scoreboard.
module tb_fetch_buffer;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  fetch_valid;
    logic [63:0] fetch_pc, fetch_inst, fetch_pre_addr;
    logic [1:0]  fetch_pretaken, fetch_is_exception;
    logic [13:0] fetch_exception_cause;
    logic        fetch_ready;
    logic        get_data_req;
    logic [1:0]  valid;
    logic [63:0] pc, inst, pre_addr_in;
    logic [1:0]  pretaken, is_exception;
    logic [13:0] exception_cause;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
        .fetch_pretaken(fetch_pretaken), .fetch_pre_addr(fetch_pre_addr),
        .fetch_is_exception(fetch_is_exception), .fetch_exception_cause(fetch_exception_cause),
        .fetch_ready(fetch_ready), .get_data_req(get_data_req),
        .valid(valid), .pc(pc), .inst(inst), .pretaken(pretaken), .pre_addr_in(pre_addr_in),
        .is_exception(is_exception), .exception_cause(exception_cause)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pretaken;
        logic [31:0] pre_addr;
        logic        is_exc;
        logic [6:0]  cause;
    } entry_t;

    typedef struct packed {
        logic [1:0] vld;
        entry_t     e1;
        entry_t     e0;
    } exp_t;

    typedef struct packed {
        logic       fl;
        logic [1:0] fv;
        logic       rq;
        logic       rdy;
        logic [1:0] vld;
    } vec_t;

    entry_t mq[$];
    exp_t   sb[$];
    vec_t   vt[$];
    int     nvec = 0;
    int     nerr = 0;
    int     seq  = 0;

    function automatic entry_t mk(input int s, input int slot);
        entry_t e;
        logic [31:0] p;
        p          = 32'h1c00_0000 + 32'(s * 8 + slot * 4);
        e.pc       = p;
        e.inst     = p ^ 32'hdead_beef;
        e.pretaken = p[3];
        e.pre_addr = p + 32'h40;
        e.is_exc   = p[4];
        e.cause    = p[9:3];
        return e;
    endfunction

    function automatic entry_t dut_slot(input int i);
        entry_t e;
        e.pc       = pc[i*32 +: 32];
        e.inst     = inst[i*32 +: 32];
        e.pretaken = pretaken[i];
        e.pre_addr = pre_addr_in[i*32 +: 32];
        e.is_exc   = is_exception[i];
        e.cause    = exception_cause[i*7 +: 7];
        return e;
    endfunction

    // Drive one cycle, predict through the model, then compare after the edge.
    task automatic apply(input logic fl, input logic [1:0] fv, input logic rq,
                         input logic exp_rdy, input logic [1:0] exp_vld, input int idx);
        entry_t e0, e1, got;
        exp_t   x;
        int     n;
        logic   acc;
        e0 = mk(seq, 0);
        e1 = mk(seq, 1);
        seq++;
        flush                 = fl;
        fetch_valid           = fv;
        get_data_req          = rq;
        fetch_pc              = {e1.pc, e0.pc};
        fetch_inst            = {e1.inst, e0.inst};
        fetch_pretaken        = {e1.pretaken, e0.pretaken};
        fetch_pre_addr        = {e1.pre_addr, e0.pre_addr};
        fetch_is_exception    = {e1.is_exc, e0.is_exc};
        fetch_exception_cause = {e1.cause, e0.cause};
        #1;
        nvec++;
        if (fetch_ready !== exp_rdy) begin
            nerr++;
            $display("FAIL ready[%0d]: got %b want %b", idx, fetch_ready, exp_rdy);
        end
        acc = !fl && (fv != 2'b00) && (mq.size() <= DEPTH - 2);
        x   = '0;
        if (fl) begin
            mq.delete();
        end else begin
            n = rq ? ((mq.size() >= 2) ? 2 : mq.size()) : 0;
            x.vld = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
            if (n >= 1) x.e0 = mq.pop_front();
            if (n == 2) x.e1 = mq.pop_front();
            if (acc && fv[0]) mq.push_back(e0);
            if (acc && fv[1]) mq.push_back(e1);
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        nvec++;
        if (valid !== exp_vld || valid !== x.vld) begin
            nerr++;
            $display("FAIL valid[%0d]: got %b want %b (model %b)", idx, valid, exp_vld, x.vld);
        end
        for (int i = 0; i < 2; i++) begin
            if (x.vld[i]) begin
                got = dut_slot(i);
                nvec++;
                if (got !== ((i == 0) ? x.e0 : x.e1)) begin
                    nerr++;
                    $display("FAIL payload[%0d] slot%0d: got %h want %h", idx, i, got,
                             (i == 0) ? x.e0 : x.e1);
                end
            end
        end
    endtask

    task automatic check_zero(input string nm);
        nvec++;
        if ({valid, pc, inst, pretaken, pre_addr_in, is_exception, exception_cause} !== '0) begin
            nerr++;
            $display("FAIL %s: got valid %b pc %h inst %h, want all zero", nm, valid, pc, inst);
        end
    endtask

    initial begin
        // {flush, fetch_valid, get_data_req, expected ready, expected valid}
        vt.push_back('{1'b0, 2'b11, 1'b0, 1'b1, 2'b00}); // single pair
        vt.push_back('{1'b0, 2'b00, 1'b1, 1'b1, 2'b11});
        vt.push_back('{1'b0, 2'b10, 1'b0, 1'b1, 2'b00}); // compaction
        vt.push_back('{1'b0, 2'b01, 1'b0, 1'b1, 2'b00});
        vt.push_back('{1'b0, 2'b00, 1'b1, 1'b1, 2'b11});
        vt.push_back('{1'b0, 2'b01, 1'b1, 1'b1, 2'b00}); // no bypass
        vt.push_back('{1'b0, 2'b00, 1'b1, 1'b1, 2'b01}); // odd occupancy
        vt.push_back('{1'b0, 2'b00, 1'b1, 1'b1, 2'b00});
        for (int i = 0; i < 4; i++)
            vt.push_back('{1'b0, 2'b11, 1'b0, 1'b1, 2'b00}); // fill to 8
        vt.push_back('{1'b0, 2'b11, 1'b0, 1'b0, 2'b00}); // ignored when full
        vt.push_back('{1'b0, 2'b00, 1'b1, 1'b0, 2'b11});
        vt.push_back('{1'b0, 2'b00, 1'b0, 1'b1, 2'b00}); // recovered
        vt.push_back('{1'b0, 2'b11, 1'b1, 1'b1, 2'b11}); // simultaneous rd/wr
        for (int i = 0; i < 3; i++)
            vt.push_back('{1'b0, 2'b00, 1'b1, 1'b1, 2'b11}); // drain, tail at 7
        vt.push_back('{1'b0, 2'b11, 1'b0, 1'b1, 2'b00}); // straddles 7 -> 0
        vt.push_back('{1'b0, 2'b00, 1'b1, 1'b1, 2'b11});
        vt.push_back('{1'b0, 2'b11, 1'b0, 1'b1, 2'b00});
        vt.push_back('{1'b0, 2'b11, 1'b1, 1'b1, 2'b11});
        vt.push_back('{1'b1, 2'b11, 1'b1, 1'b0, 2'b00}); // flush wins
        vt.push_back('{1'b0, 2'b00, 1'b1, 1'b1, 2'b00});
        vt.push_back('{1'b0, 2'b01, 1'b0, 1'b1, 2'b00});
        vt.push_back('{1'b0, 2'b00, 1'b1, 1'b1, 2'b01});

        rst = 1'b0;
        flush = 1'b0;
        fetch_valid = '0;
        get_data_req = 1'b0;
        fetch_pc = '0;
        fetch_inst = '0;
        fetch_pretaken = '0;
        fetch_pre_addr = '0;
        fetch_is_exception = '0;
        fetch_exception_cause = '0;
        #3;
        check_zero("reset_outputs");
        #9 rst = 1'b1;
        #1;
        nvec++;
        if (fetch_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_ready: got %b want 1", fetch_ready);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < vt.size(); i++)
            apply(vt[i].fl, vt[i].fv, vt[i].rq, vt[i].rdy, vt[i].vld, i);

        // Reach count 5 with live outputs, then reset between edges.
        apply(1'b0, 2'b11, 1'b0, 1'b1, 2'b00, 100);
        apply(1'b0, 2'b11, 1'b0, 1'b1, 2'b00, 101);
        apply(1'b0, 2'b11, 1'b0, 1'b1, 2'b00, 102);
        apply(1'b0, 2'b01, 1'b1, 1'b1, 2'b11, 103);
        fetch_valid  = 2'b00;
        get_data_req = 1'b0;
        rst = 1'b0;
        #1;
        check_zero("async_reset");
        #2 rst = 1'b1;
        mq.delete();
        sb.delete();
        apply(1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 104);
        apply(1'b0, 2'b11, 1'b0, 1'b1, 2'b00, 105);
        apply(1'b0, 2'b00, 1'b1, 1'b1, 2'b11, 106);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
